// File: rtl/vanilla_remote_req_responder.sv
// ============================================================================
// vanilla_remote_req_responder
//   Target-side servicer for vanilla-core remote loads, stores and AMOs.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package bsg_vanilla_pkg;

  typedef struct packed {
    logic       float_wb;
    logic       is_unsigned_op;
    logic       is_byte_op;
    logic       is_hex_op;
    logic [1:0] part_sel;
  } load_info_s;

  typedef struct packed {
    logic        write_not_read;
    logic        is_amo_op;
    logic [1:0]  amo_type;
    logic [3:0]  mask;
    load_info_s  load_info;
    logic [4:0]  reg_id;
    logic [31:0] data;
    logic [31:0] addr;
  } remote_req_s;

  typedef struct packed {
    logic        float_wb;
    logic        is_unsigned_op;
    logic        is_byte_op;
    logic        is_hex_op;
    logic [1:0]  part_sel;
    logic [4:0]  reg_id;
    logic [31:0] data;
  } remote_load_resp_s;

  localparam logic [1:0] c_amo_swap = 2'b00;
  localparam logic [1:0] c_amo_or   = 2'b01;
  localparam logic [1:0] c_amo_add  = 2'b10;

endpackage

module vanilla_remote_req_responder
  import bsg_vanilla_pkg::*;
#(
  parameter int addr_width_p = 16
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic                                  req_v_i,
  input  logic [$bits(remote_req_s)-1:0]        req_i,
  output logic                                  req_ready_o,
  output logic                                  mem_v_o,
  output logic                                  mem_w_o,
  output logic [addr_width_p-1:0]               mem_addr_o,
  output logic [31:0]                           mem_data_o,
  output logic [3:0]                            mem_mask_o,
  input  logic [31:0]                           mem_data_i,
  output logic                                  resp_v_o,
  output logic [$bits(remote_load_resp_s)-1:0]  resp_o,
  input  logic                                  resp_yumi_i
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    AMO_WR = 3'd3,
    RESP   = 3'd4
  } state_e;

  state_e             r_state;
  remote_req_s        r_req;
  logic [31:0]        r_old;
  logic               r_ready;
  logic               r_mem_v;
  logic               r_mem_w;
  logic [addr_width_p-1:0] r_mem_addr;
  logic [31:0]        r_mem_data;
  logic [3:0]         r_mem_mask;
  logic               r_resp_v;
  remote_load_resp_s  r_resp;

  remote_req_s        w_req_in;
  logic               w_is_store_in;
  logic [31:0]        w_amo_data;
  logic               w_amo_valid;
  logic               w_unused;

  assign w_req_in      = req_i;
  assign w_is_store_in = w_req_in.write_not_read & ~w_req_in.is_amo_op;

  // Address and mask are consumed straight from the input at accept time.
  assign w_unused = ^{w_req_in.addr, r_req.addr, r_req.mask};

  // The AMO result is formed from the read data as it arrives in WAIT.
  always_comb begin
    w_amo_data  = 32'h0;
    w_amo_valid = 1'b1;
    case (r_req.amo_type)
      c_amo_swap: w_amo_data = r_req.data;
      c_amo_or:   w_amo_data = mem_data_i | r_req.data;
      c_amo_add:  w_amo_data = mem_data_i + r_req.data;
      default:    w_amo_valid = 1'b0;
    endcase
  end

  function automatic remote_load_resp_s make_resp(input remote_req_s req,
                                                  input logic [31:0] word);
    remote_load_resp_s resp;
    resp                = '0;
    resp.float_wb       = req.load_info.float_wb;
    resp.is_unsigned_op = req.load_info.is_unsigned_op;
    resp.is_byte_op     = req.load_info.is_byte_op;
    resp.is_hex_op      = req.load_info.is_hex_op;
    resp.part_sel       = req.load_info.part_sel;
    resp.reg_id         = req.reg_id;
    resp.data           = word;
    return resp;
  endfunction

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= IDLE;
      r_req      <= '0;
      r_old      <= '0;
      r_ready    <= 1'b1;
      r_mem_v    <= 1'b0;
      r_mem_w    <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_mask <= '0;
      r_resp_v   <= 1'b0;
      r_resp     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_v_i) begin
            r_req      <= w_req_in;
            r_state    <= ISSUE;
            r_ready    <= 1'b0;
            r_mem_v    <= 1'b1;
            r_mem_w    <= w_is_store_in;
            r_mem_addr <= w_req_in.addr[addr_width_p+1:2];
            r_mem_data <= w_is_store_in ? w_req_in.data : 32'h0;
            r_mem_mask <= w_is_store_in ? w_req_in.mask : 4'h0;
          end
        end
        ISSUE: begin
          r_mem_v    <= 1'b0;
          r_mem_w    <= 1'b0;
          r_mem_data <= '0;
          r_mem_mask <= '0;
          if (r_req.write_not_read & ~r_req.is_amo_op) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_old <= mem_data_i;
          if (r_req.is_amo_op) begin
            r_state    <= AMO_WR;
            r_mem_v    <= w_amo_valid;
            r_mem_w    <= w_amo_valid;
            r_mem_data <= w_amo_valid ? w_amo_data : 32'h0;
            r_mem_mask <= w_amo_valid ? 4'hF : 4'h0;
          end else begin
            r_state  <= RESP;
            r_resp_v <= 1'b1;
            r_resp   <= make_resp(r_req, mem_data_i);
          end
        end
        AMO_WR: begin
          r_mem_v    <= 1'b0;
          r_mem_w    <= 1'b0;
          r_mem_data <= '0;
          r_mem_mask <= '0;
          r_state    <= RESP;
          r_resp_v   <= 1'b1;
          r_resp     <= make_resp(r_req, r_old);
        end
        RESP: begin
          if (resp_yumi_i) begin
            r_state  <= IDLE;
            r_ready  <= 1'b1;
            r_resp_v <= 1'b0;
            r_resp   <= '0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_ready    <= 1'b1;
          r_mem_v    <= 1'b0;
          r_mem_w    <= 1'b0;
          r_resp_v   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = r_ready;
  assign mem_v_o     = r_mem_v;
  assign mem_w_o     = r_mem_w;
  assign mem_addr_o  = r_mem_addr;
  assign mem_data_o  = r_mem_data;
  assign mem_mask_o  = r_mem_mask;
  assign resp_v_o    = r_resp_v;
  assign resp_o      = r_resp;

endmodule

`default_nettype wire

// File: tb/tb_vanilla_remote_req_responder.sv
// ============================================================================
// tb_vanilla_remote_req_responder
//   Directed bench with an SRAM model and a response scoreboard.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vanilla_remote_req_responder;
  import bsg_vanilla_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_v = 1'b0;
  remote_req_s       req = '0;
  logic              ready;
  logic              mem_v, mem_w;
  logic [15:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_mask;
  logic [31:0]       mem_rdata = 32'h0;
  logic              resp_v;
  remote_load_resp_s resp;
  logic              resp_yumi = 1'b0;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [31:0] mem [0:63];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;

  remote_load_resp_s exp_q[$];

  vanilla_remote_req_responder #(.addr_width_p(16)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .req_v_i     (req_v),
    .req_i       (req),
    .req_ready_o (ready),
    .mem_v_o     (mem_v),
    .mem_w_o     (mem_w),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_wdata),
    .mem_mask_o  (mem_mask),
    .mem_data_i  (mem_rdata),
    .resp_v_o    (resp_v),
    .resp_o      (resp),
    .resp_yumi_i (resp_yumi)
  );

  always #5 clk = ~clk;

  // SRAM model: byte-masked write, one-cycle read latency.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (mem_v) begin
      if (mem_w) begin
        wr_cnt <= wr_cnt + 1;
        for (int b = 0; b < 4; b++)
          if (mem_mask[b]) mem[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        rd_cnt    <= rd_cnt + 1;
        mem_rdata <= mem[mem_addr[5:0]];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input string tag);
    remote_load_resp_s e;
    if (exp_q.size() == 0) begin
      n_asserts++;
      n_fail++;
      $error("FAIL %s: observed response %0h expected none queued", tag, resp);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 64'(resp), 64'(e));
    end
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  function automatic remote_req_s mk_req(input logic wnr, input logic amo,
      input logic [1:0] t, input logic [3:0] mask, input logic [31:0] addr,
      input logic [31:0] data, input logic [4:0] reg_id, input load_info_s li);
    remote_req_s r;
    r = '0;
    r.write_not_read = wnr; r.is_amo_op = amo; r.amo_type = t; r.mask = mask;
    r.addr = addr; r.data = data; r.reg_id = reg_id; r.load_info = li;
    return r;
  endfunction

  function automatic remote_load_resp_s mk_exp(input logic [4:0] reg_id,
      input load_info_s li, input logic [31:0] data);
    remote_load_resp_s e;
    e.float_wb = li.float_wb; e.is_unsigned_op = li.is_unsigned_op;
    e.is_byte_op = li.is_byte_op; e.is_hex_op = li.is_hex_op;
    e.part_sel = li.part_sel; e.reg_id = reg_id; e.data = data;
    return e;
  endfunction

  // Drive one request for the accept cycle C; returns in C+1.
  task automatic send(input remote_req_s r);
    chk("ready_before_accept", 64'(ready), 64'd1);
    req = r; req_v = 1'b1;
    tick();
    req_v = 1'b0; req = '0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr,
      input logic [4:0] reg_id, input load_info_s li, input logic [31:0] old);
    exp_q.push_back(mk_exp(reg_id, li, old));
    send(mk_req(1'b0, 1'b0, 2'b00, 4'hF, addr, 32'h0, reg_id, li));
    chk({tag, "_rd_v"}, 64'({mem_v, mem_w}), 64'b10);
    chk({tag, "_rd_addr"}, 64'(mem_addr), 64'(addr[17:2]));
    tick();
    chk({tag, "_no_resp_c2"}, 64'(resp_v), 64'd0);
    tick();
    chk({tag, "_resp_v_c3"}, 64'(resp_v), 64'd1);
    chk_resp({tag, "_resp"});
    resp_yumi = 1'b1;
    tick();
    resp_yumi = 1'b0;
    chk({tag, "_idle"}, 64'({ready, resp_v}), 64'b10);
  endtask

  task automatic do_amo(input string tag, input logic [31:0] addr, input logic [1:0] t,
      input logic [31:0] data, input logic [31:0] old, input logic wr_v,
      input logic [31:0] wdata);
    load_info_s li;
    li = '0;
    exp_q.push_back(mk_exp(5'd9, li, old));
    send(mk_req(1'b1, 1'b1, t, 4'h0, addr, data, 5'd9, li));
    chk({tag, "_rd_c1"}, 64'({mem_v, mem_w}), 64'b10);
    tick();
    chk({tag, "_idle_c2"}, 64'(mem_v), 64'd0);
    tick();
    chk({tag, "_wr_c3"}, 64'({mem_v, mem_w}), 64'({wr_v, wr_v}));
    if (wr_v) begin
      chk({tag, "_wdata"}, 64'(mem_wdata), 64'(wdata));
      chk({tag, "_wmask"}, 64'(mem_mask), 64'hF);
      chk({tag, "_waddr"}, 64'(mem_addr), 64'(addr[17:2]));
    end
    tick();
    chk({tag, "_resp_v_c4"}, 64'(resp_v), 64'd1);
    chk_resp({tag, "_resp"});
    resp_yumi = 1'b1;
    tick();
    resp_yumi = 1'b0;
    chk({tag, "_mem_after"}, 64'(mem[addr[7:2]]), 64'(wr_v ? wdata : old));
  endtask

  initial begin
    load_info_s li0, li_meta;
    remote_load_resp_s held;
    int acc0, seen;
    li0 = '0;

    // Reset state
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_outs", 64'({mem_v, mem_w, mem_addr, mem_mask, resp_v}), 64'd0);
    chk("reset_wdata", 64'(mem_wdata), 64'd0);
    chk("reset_resp", 64'(resp), 64'd0);

    // Reset while a load sits in WAIT
    preload(6'd8, 32'h12345678);
    send(mk_req(1'b0, 1'b0, 2'b00, 4'h0, 32'h20, 32'h0, 5'd2, li0));
    tick();
    acc0 = wr_cnt;
    reset_n = 1'b0;
    #1;
    chk("rst_async_ready", 64'({ready, resp_v, mem_v}), 64'b100);
    tick(); tick();
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (resp_v) seen++;
    end
    chk("rst_mid_no_resp", 64'(seen), 64'd0);
    chk("rst_mid_no_write", 64'(wr_cnt), 64'(acc0));
    chk("rst_mid_ready", 64'(ready), 64'd1);
    chk("rst_mid_outs", 64'({mem_v, mem_w, mem_addr, mem_wdata, mem_mask, resp_v}), 64'd0);
    chk("rst_mid_resp", 64'(resp), 64'd0);

    // Masked store then load
    preload(6'd4, 32'h11223344);
    send(mk_req(1'b1, 1'b0, 2'b00, 4'b0101, 32'h10, 32'hAABBCCDD, 5'd0, li0));
    chk("st_wr_c1", 64'({mem_v, mem_w}), 64'b11);
    chk("st_addr", 64'(mem_addr), 64'd4);
    chk("st_mask", 64'(mem_mask), 64'b0101);
    chk("st_data", 64'(mem_wdata), 64'hAABBCCDD);
    tick();
    chk("st_ready_c2", 64'({ready, mem_v, resp_v}), 64'b100);
    chk("st_mem", 64'(mem[4]), 64'h11BB33DD);
    do_load("ld_masked", 32'h10, 5'd7, li0, 32'h11BB33DD);

    // AMOs
    preload(6'd5, 32'hFFFFFFFF);
    do_amo("amo_add_wrap", 32'h14, c_amo_add, 32'h2, 32'hFFFFFFFF, 1'b1, 32'h1);
    preload(6'd6, 32'hA);
    do_amo("amo_swap", 32'h18, c_amo_swap, 32'h5, 32'hA, 1'b1, 32'h5);
    preload(6'd7, 32'hA);
    do_amo("amo_or", 32'h1C, c_amo_or, 32'h5, 32'hA, 1'b1, 32'hF);
    preload(6'd9, 32'hA);
    do_amo("amo_rsvd", 32'h24, 2'b11, 32'h5, 32'hA, 1'b0, 32'h0);

    // Response back-pressure with a request waiting
    preload(6'd10, 32'hCAFEF00D);
    preload(6'd11, 32'h0BADBEEF);
    exp_q.push_back(mk_exp(5'd3, li0, 32'hCAFEF00D));
    send(mk_req(1'b0, 1'b0, 2'b00, 4'h0, 32'h28, 32'h0, 5'd3, li0));
    tick(); tick();
    chk("bp_resp_v", 64'(resp_v), 64'd1);
    held = resp;
    req = mk_req(1'b0, 1'b0, 2'b00, 4'h0, 32'h2C, 32'h0, 5'd4, li0);
    req_v = 1'b1;
    acc0 = rd_cnt + wr_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ready_low", 64'(ready), 64'd0);
      chk("bp_resp_stable", 64'({resp_v, resp}), 64'({1'b1, held}));
    end
    chk("bp_no_sram", 64'(rd_cnt + wr_cnt), 64'(acc0));
    chk_resp("bp_resp");
    resp_yumi = 1'b1;
    tick();
    resp_yumi = 1'b0;
    chk("bp_ready_after_yumi", 64'(ready), 64'd1);
    exp_q.push_back(mk_exp(5'd4, li0, 32'h0BADBEEF));
    tick();
    req_v = 1'b0; req = '0;
    chk("bp_next_accept", 64'({mem_v, mem_w, mem_addr}), 64'({2'b10, 16'd11}));
    tick(); tick();
    chk("bp2_resp_v", 64'(resp_v), 64'd1);
    chk_resp("bp2_resp");
    resp_yumi = 1'b1;
    tick();
    resp_yumi = 1'b0;

    // Load metadata passthrough
    li_meta = '0;
    li_meta.float_wb = 1'b1;
    li_meta.is_byte_op = 1'b1;
    li_meta.part_sel = 2'b11;
    li_meta.is_unsigned_op = 1'b1;
    preload(6'd12, 32'h89ABCDEF);
    do_load("ld_meta", 32'h30, 5'd31, li_meta, 32'h89ABCDEF);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
